pulpino_mailbox_apb: RTL and testbench
======================================

# pulpino_mailbox_apb

PULPino-side end of the USB↔PULPino mailbox. An APB slave on the PULPino peripheral bus lets the core receive 32-bit words the host wrote into the usb_to_pulpino register and send 32-bit words back through pulpino_to_usb. Transfers use a two-toggle handshake carried on the ext_to_pulpino / pulpino_to_ext flag words. The block runs entirely in the crypto_clk domain; the host-written inputs cross in through synchronizers inside this block.

## Interface
Parameters:
- pRX_DEPTH, 4: RX FIFO depth in words; power of two, 2..16.
- pAPB_AW, 12: APB address width.

Ports:
- crypto_clk  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- paddr  in  pAPB_AW  APB address; bits [3:2] decoded.
- psel / penable / pwrite  in  1 each  APB control.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  constant 1 (zero wait states).
- pslverr  out  1  error response.
- usb_to_pulpino_i  in  32  host data word, quasi-static.
- ext_to_pulpino_flags_i  in  32  host flags: bit0 = RX request toggle, bit1 = TX ack toggle; other bits ignored.
- pulpino_to_usb_o  out  32  TX data word.
- pulpino_to_ext_flags_o  out  32  bit0 = RX ack toggle, bit1 = TX valid toggle; bits [31:2] = 0.
- irq_o  out  1  RX-not-empty interrupt.

## Operation
- APB registers, word offsets:
  - 0x0 RX_DATA (RO): a read pops the FIFO head.
  - 0x4 TX_DATA (WO).
  - 0x8 STATUS (RO): [0] rx_empty, [1] rx_full, [2] tx_busy, [7:3] rx_count.
  - 0xC IRQ_EN (RW): only bit [0] is used.
- Access happens on psel&penable. Unmapped offsets read 0 and are written without effect, with pslverr=0.
- RX path:
  - ext bit0 passes through 2 flops, then a previous-value flop.
  - rx_req_edge = sync2 ^ prev.
  - On an edge, the block sets rx_pending.
  - While rx_pending is set and the FIFO is not full, the block pushes usb_to_pulpino_i, clears rx_pending and toggles ack bit0 on the same cycle.
  - While the FIFO is full, rx_pending holds. No ack is given, which back-pressures the host.
  - A second edge while rx_pending=1 is a host protocol violation and is not tracked (the pending flag stays set).
- RX read:
  - Reading RX_DATA while not empty returns the head and pops it.
  - Reading RX_DATA while empty returns 0 with pslverr=1, and the FIFO is unchanged.
- TX path:
  - An APB write to TX_DATA while tx_busy=0 loads pulpino_to_usb_o, toggles valid bit1 and sets tx_busy.
  - ext bit1 is synchronized and edge-detected in the same way as bit0. An edge clears tx_busy.
  - A TX_DATA write while tx_busy=1 is dropped with pslverr=1.
- FIFO:
  - Pointers are (log2 pRX_DEPTH)-bit and wrap naturally.
  - count is (log2 pRX_DEPTH + 1)-bit.
  - A push and a pop in the same cycle leave count unchanged; the write lands at the tail and the read takes the old head.
- Reset:
  - All outputs, toggles, synchronizers, the FIFO, rx_pending, tx_busy and IRQ_EN go to 0.
  - The host side shares reset_i, so the toggle phases realign.
  - A transfer in flight at reset is lost.

## Timing
- A host toggle reaches sync2 in 2 cycles; the edge is seen in cycle 3.
- The push and ack toggle follow in cycle 4 when there is space: 4 cycles from toggle to ack.
- usb_to_pulpino_i is sampled in the push cycle only. The host must write the data before the toggle, and it stays stable until ack.
- prdata is combinational in the APB access phase. The pop takes effect at the end of that cycle.
- The STATUS/irq update is visible the next cycle.
- When the FIFO is full and rx_pending=1, a pop in cycle N frees a slot. The pending push and ack then occur in cycle N+1.
- A TX_DATA write in cycle N gives: pulpino_to_usb_o valid and the bit1 toggle at N+1, and tx_busy=1 from N+1.
- irq_o is registered: it equals IRQ_EN[0] & !rx_empty, delayed one cycle.

## Configuration
- MAILBOX_IRQ_EN defined:
  - The IRQ_EN register and the irq_o flop are present.
- Not defined:
  - irq_o is tied to 0.
  - 0xC reads 0 and ignores writes.
  - The rest of the behaviour is identical.

## Structure
- Package pulpino_mailbox_pkg holds:
  - the register offset constants (RX_DATA, TX_DATA, STATUS, IRQ_EN);
  - the STATUS bit positions;
  - the flag bit indices (RX_REQ=0, TX_ACK=1, RX_ACK=0, TX_VALID=1).
- Sub-module mailbox_fifo is a synchronous FIFO with width 32 and depth pRX_DEPTH. It has push, pop, full, empty and count. Its asynchronous reset clears the pointers.
- Synchronizer and edge-detect flops stay in the top module.

## Test plan
- Reset, then read STATUS → 0x1 (empty). pulpino_to_ext_flags_o=0, irq_o=0.
- Set usb_to_pulpino_i=0xDEADBEEF and toggle ext bit0 → RX ack bit0 toggles exactly 4 cycles later. Then read RX_DATA → 0xDEADBEEF, and STATUS returns to empty.
- Push 5 words (0x1..0x5) with pRX_DEPTH=4:
  - The 5th word gets no ack and STATUS = full, count 4.
  - Pop 0x1 → the 5th word is acked the next cycle.
  - Subsequent pops return 0x2..0x5 in order.
- Write TX_DATA=0xCAFEF00D → output valid and bit1 toggled at N+1, tx_busy=1. A second write gives pslverr=1 and the output stays 0xCAFEF00D. Toggle ext bit1 → tx_busy clears 3 cycles later.
- Read RX_DATA while empty → prdata=0, pslverr=1, count stays 0. Assert reset_i mid-transfer with 2 words queued → count=0 and flags=0 immediately.
- With MAILBOX_IRQ_EN: IRQ_EN=1 plus one RX word → irq_o=1 one cycle after the push, and 0 one cycle after the pop. Without the macro: irq_o stays 0.

Source files
------------

// File: rtl/pulpino_mailbox_pkg.sv
// Shared constants for the PULPino-side USB mailbox: APB register map,
// STATUS bit layout and the flag-word bit indices used by the toggle handshake.
package pulpino_mailbox_pkg;

    // Word index decoded from paddr[3:2]
    localparam logic [1:0] REG_RX_DATA = 2'd0;
    localparam logic [1:0] REG_TX_DATA = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_IRQ_EN  = 2'd3;

    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_BUSY      = 2;
    localparam int ST_RX_COUNT_LSB = 3;
    localparam int ST_RX_COUNT_MSB = 7;

    // Host -> PULPino flag bits
    localparam int FLAG_RX_REQ = 0;
    localparam int FLAG_TX_ACK = 1;
    // PULPino -> host flag bits
    localparam int FLAG_RX_ACK   = 0;
    localparam int FLAG_TX_VALID = 1;

    function automatic logic [31:0] pack_status(input logic       rx_empty,
                                                input logic       rx_full,
                                                input logic       tx_busy,
                                                input logic [4:0] rx_count);
        logic [31:0] s;
        s = '0;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_TX_BUSY]  = tx_busy;
        s[ST_RX_COUNT_MSB:ST_RX_COUNT_LSB] = rx_count;
        return s;
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous RX word FIFO for the mailbox; reset clears pointers and count,
// storage is left uninitialised.
module mailbox_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pulpino_mailbox_apb.sv
// PULPino-side APB slave of the USB<->PULPino mailbox with two-toggle handshakes.
// Optional feature: define MAILBOX_IRQ_EN to add the IRQ_EN register and irq_o flop.
module pulpino_mailbox_apb
    import pulpino_mailbox_pkg::*;
#(
    parameter int pRX_DEPTH = 4,
    parameter int pAPB_AW   = 12
) (
    input  logic               crypto_clk,
    input  logic               reset_i,
    input  logic [pAPB_AW-1:0] paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [31:0]        usb_to_pulpino_i,
    input  logic [31:0]        ext_to_pulpino_flags_i,
    output logic [31:0]        pulpino_to_usb_o,
    output logic [31:0]        pulpino_to_ext_flags_o,
    output logic               irq_o
);
    localparam int CW = $clog2(pRX_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          rd_access;
    logic          wr_access;

    logic          rx_req_s1, rx_req_s2, rx_req_prev;
    logic          tx_ack_s1, tx_ack_s2, tx_ack_prev;
    logic          rx_req_edge;
    logic          tx_ack_edge;

    logic          rx_pending;
    logic          rx_ack;
    logic          tx_valid;
    logic          tx_busy;
    logic          tx_load;

    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] rx_count;
    logic          irq_en_rd;

    // Only paddr[3:2] and the two handshake flag bits are meaningful
    logic unused_bits;
    assign unused_bits = ^{paddr[pAPB_AW-1:4], paddr[1:0], ext_to_pulpino_flags_i[31:2]};

    assign pready    = 1'b1;
    assign reg_sel   = paddr[3:2];
    assign rd_access = psel & penable & ~pwrite;
    assign wr_access = psel & penable & pwrite;

    assign rx_req_edge = rx_req_s2 ^ rx_req_prev;
    assign tx_ack_edge = tx_ack_s2 ^ tx_ack_prev;

    assign fifo_push = rx_pending & ~fifo_full;
    assign fifo_pop  = rd_access & (reg_sel == REG_RX_DATA) & ~fifo_empty;
    assign tx_load   = wr_access & (reg_sel == REG_TX_DATA) & ~tx_busy;

    // Stage: host flag synchronizers and edge-detect history
    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            rx_req_s1   <= 1'b0;
            rx_req_s2   <= 1'b0;
            rx_req_prev <= 1'b0;
            tx_ack_s1   <= 1'b0;
            tx_ack_s2   <= 1'b0;
            tx_ack_prev <= 1'b0;
        end else begin
            rx_req_s1   <= ext_to_pulpino_flags_i[FLAG_RX_REQ];
            rx_req_s2   <= rx_req_s1;
            rx_req_prev <= rx_req_s2;
            tx_ack_s1   <= ext_to_pulpino_flags_i[FLAG_TX_ACK];
            tx_ack_s2   <= tx_ack_s1;
            tx_ack_prev <= tx_ack_s2;
        end
    end

    // Stage: handshake state; an edge coinciding with the push of the
    // previous request is a host protocol violation and is dropped
    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            rx_pending       <= 1'b0;
            rx_ack           <= 1'b0;
            tx_valid         <= 1'b0;
            tx_busy          <= 1'b0;
            pulpino_to_usb_o <= '0;
        end else begin
            if (fifo_push)        rx_pending <= 1'b0;
            else if (rx_req_edge) rx_pending <= 1'b1;

            if (fifo_push) rx_ack <= ~rx_ack;

            if (tx_load) begin
                pulpino_to_usb_o <= pwdata;
                tx_valid         <= ~tx_valid;
                tx_busy          <= 1'b1;
            end else if (tx_ack_edge) begin
                tx_busy <= 1'b0;
            end
        end
    end

    mailbox_fifo #(
        .DATA_W (32),
        .DEPTH  (pRX_DEPTH)
    ) u_rx_fifo (
        .clk   (crypto_clk),
        .rst   (reset_i),
        .push  (fifo_push),
        .wdata (usb_to_pulpino_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rx_count)
    );

`ifdef MAILBOX_IRQ_EN
    logic irq_en;
    logic irq_q;

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_access && (reg_sel == REG_IRQ_EN)) irq_en <= pwdata[0];
            irq_q <= irq_en & ~fifo_empty;
        end
    end

    assign irq_o     = irq_q;
    assign irq_en_rd = irq_en;
`else
    assign irq_o     = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        pulpino_to_ext_flags_o                = '0;
        pulpino_to_ext_flags_o[FLAG_RX_ACK]   = rx_ack;
        pulpino_to_ext_flags_o[FLAG_TX_VALID] = tx_valid;
    end

    // Read data is combinational; the RX pop lands on the closing clock edge
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (psel && !pwrite) begin
            case (reg_sel)
                REG_RX_DATA: prdata = fifo_empty ? 32'h0 : fifo_rdata;
                REG_STATUS:  prdata = pack_status(fifo_empty, fifo_full, tx_busy, 5'(rx_count));
                REG_IRQ_EN:  prdata = {31'b0, irq_en_rd};
                default:     prdata = '0;
            endcase
        end
        if (rd_access && (reg_sel == REG_RX_DATA) && fifo_empty) pslverr = 1'b1;
        if (wr_access && (reg_sel == REG_TX_DATA) && tx_busy)    pslverr = 1'b1;
    end

endmodule

// File: tb/tb_pulpino_mailbox_apb.sv
// Self-checking bench for pulpino_mailbox_apb: a queue-based mailbox model
// drives expectations for RX, TX, FIFO boundaries, reset and the optional IRQ.
module tb_pulpino_mailbox_apb;
    localparam int DEPTH = 4;
    localparam logic [11:0] A_RX = 12'h000;
    localparam logic [11:0] A_TX = 12'h004;
    localparam logic [11:0] A_ST = 12'h008;
    localparam logic [11:0] A_IE = 12'h00C;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [31:0] usb_data;
    logic [31:0] ext_flags;
    logic [31:0] tx_out;
    logic [31:0] out_flags;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic        host_rx = 1'b0;
    logic        host_tx = 1'b0;
    logic        exp_rx_ack = 1'b0;
    logic        exp_tx_valid = 1'b0;
    logic [31:0] model_q [$];

    always #5 clk = ~clk;

    pulpino_mailbox_apb #(.pRX_DEPTH(DEPTH), .pAPB_AW(12)) dut (
        .crypto_clk             (clk),
        .reset_i                (reset_i),
        .paddr                  (paddr),
        .psel                   (psel),
        .penable                (penable),
        .pwrite                 (pwrite),
        .pwdata                 (pwdata),
        .prdata                 (prdata),
        .pready                 (pready),
        .pslverr                (pslverr),
        .usb_to_pulpino_i       (usb_data),
        .ext_to_pulpino_flags_i (ext_flags),
        .pulpino_to_usb_o       (tx_out),
        .pulpino_to_ext_flags_o (out_flags),
        .irq_o                  (irq)
    );

    function automatic logic [31:0] exp_status(input int n, input logic busy);
        return 32'((n << 3) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0) + (busy ? 4 : 0));
    endfunction

    task automatic drive_host();
        logic [31:0] junk;
        junk = $urandom;
        ext_flags = {junk[31:2], host_tx, host_rx};
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        paddr = a; pwrite = 1'b1; pwdata = d; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Presents a word, toggles the RX request and waits for the ack toggle
    task automatic host_send(input logic [31:0] w, output int lat);
        usb_data = w;
        @(negedge clk);
        host_rx = ~host_rx;
        drive_host();
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (out_flags[0] !== exp_rx_ack) begin
                lat = i;
                break;
            end
        end
        if (lat != 0) begin
            exp_rx_ack = ~exp_rx_ack;
            model_q.push_back(w);
        end
    endtask

    task automatic check_status(input string name, input logic busy);
        logic [31:0] d;
        logic e;
        apb_read(A_ST, d, e);
        tests++;
        if (d !== exp_status(model_q.size(), busy)) begin
            fails++;
            $display("FAIL %s: status got %h expected %h", name, d, exp_status(model_q.size(), busy));
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        usb_data = '0; ext_flags = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        tests++;
        if (out_flags !== 32'h0 || irq !== 1'b0 || tx_out !== 32'h0 || pready !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: flags=%h irq=%b tx=%h pready=%b expected 0/0/0/1",
                     out_flags, irq, tx_out, pready);
        end
        check_status("reset_status", 1'b0);
    endtask

    task automatic test_rx_single();
        int lat;
        logic [31:0] d;
        logic e;
        host_send(32'hDEADBEEF, lat);
        tests++;
        if (lat != 4) begin
            fails++;
            $display("FAIL rx_ack_latency: got %0d cycles expected 4", lat);
        end
        apb_read(A_RX, d, e);
        tests++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL rx_single_read: got %h err=%b expected deadbeef err=0", d, e);
        end
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_status("rx_single_status", 1'b0);
    endtask

    task automatic test_empty_read();
        logic [31:0] d;
        logic e;
        apb_read(A_RX, d, e);
        tests++;
        if (d !== 32'h0 || e !== 1'b1) begin
            fails++;
            $display("FAIL empty_read: got %h err=%b expected 0 err=1", d, e);
        end
        check_status("empty_read_status", 1'b0);
    endtask

    task automatic test_full();
        int lat;
        logic [31:0] d;
        logic e;
        bit late_ack;
        for (int i = 1; i <= DEPTH; i++) begin
            host_send(32'(i), lat);
            tests++;
            if (lat != 4) begin
                fails++;
                $display("FAIL full_fill_latency: word %0d got %0d cycles expected 4", i, lat);
            end
        end
        usb_data = 32'h5;
        @(negedge clk);
        host_rx = ~host_rx;
        drive_host();
        late_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_flags[0] !== exp_rx_ack) late_ack = 1'b1;
        end
        tests++;
        if (late_ack) begin
            fails++;
            $display("FAIL full_no_ack: ack toggled while full, expected no toggle");
        end
        check_status("full_status", 1'b0);
        apb_read(A_RX, d, e);
        tests++;
        if (d !== model_q[0] || e !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_first: got %h err=%b expected %h err=0", d, e, model_q[0]);
        end
        void'(model_q.pop_front());
        tests++;
        if (out_flags[0] !== exp_rx_ack) begin
            fails++;
            $display("FAIL full_ack_early: ack=%b expected %b", out_flags[0], exp_rx_ack);
        end
        @(negedge clk);
        tests++;
        if (out_flags[0] !== ~exp_rx_ack) begin
            fails++;
            $display("FAIL full_ack_after_pop: ack=%b expected %b", out_flags[0], ~exp_rx_ack);
        end
        exp_rx_ack = ~exp_rx_ack;
        model_q.push_back(32'h5);
        while (model_q.size() > 0) begin
            apb_read(A_RX, d, e);
            tests++;
            if (d !== model_q[0] || e !== 1'b0) begin
                fails++;
                $display("FAIL full_drain: got %h err=%b expected %h err=0", d, e, model_q[0]);
            end
            void'(model_q.pop_front());
        end
        check_status("full_drained_status", 1'b0);
    endtask

    task automatic test_rx_random();
        int lat;
        int op;
        logic [31:0] d;
        logic e;
        logic [31:0] w;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0 && model_q.size() < DEPTH) begin
                w = $urandom;
                host_send(w, lat);
                tests++;
                if (lat != 4) begin
                    fails++;
                    $display("FAIL rand_ack_latency: got %0d cycles expected 4", lat);
                end
            end else if (op == 2) begin
                check_status("rand_status", 1'b0);
            end else begin
                apb_read(A_RX, d, e);
                tests++;
                if (model_q.size() == 0) begin
                    if (d !== 32'h0 || e !== 1'b1) begin
                        fails++;
                        $display("FAIL rand_empty_read: got %h err=%b expected 0 err=1", d, e);
                    end
                end else begin
                    if (d !== model_q[0] || e !== 1'b0) begin
                        fails++;
                        $display("FAIL rand_read: got %h err=%b expected %h err=0", d, e, model_q[0]);
                    end
                    void'(model_q.pop_front());
                end
            end
        end
        while (model_q.size() > 0) begin
            apb_read(A_RX, d, e);
            tests++;
            if (d !== model_q[0]) begin
                fails++;
                $display("FAIL rand_drain: got %h expected %h", d, model_q[0]);
            end
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_tx();
        logic e;
        logic [31:0] d;
        logic [31:0] w2;
        apb_write(A_TX, 32'hCAFEF00D, e);
        exp_tx_valid = ~exp_tx_valid;
        tests++;
        if (e !== 1'b0 || tx_out !== 32'hCAFEF00D || out_flags[1] !== exp_tx_valid) begin
            fails++;
            $display("FAIL tx_load: err=%b out=%h valid=%b expected 0/cafef00d/%b",
                     e, tx_out, out_flags[1], exp_tx_valid);
        end
        check_status("tx_busy_set", 1'b1);
        apb_write(A_TX, 32'h12345678, e);
        tests++;
        if (e !== 1'b1 || tx_out !== 32'hCAFEF00D || out_flags[1] !== exp_tx_valid) begin
            fails++;
            $display("FAIL tx_busy_write: err=%b out=%h valid=%b expected 1/cafef00d/%b",
                     e, tx_out, out_flags[1], exp_tx_valid);
        end
        // Ack toggle: still busy two cycles later
        host_tx = ~host_tx;
        drive_host();
        check_status("tx_busy_before_ack", 1'b1);
        check_status("tx_busy_cleared", 1'b0);

        w2 = $urandom;
        apb_write(A_TX, w2, e);
        exp_tx_valid = ~exp_tx_valid;
        tests++;
        if (e !== 1'b0 || tx_out !== w2 || out_flags[1] !== exp_tx_valid) begin
            fails++;
            $display("FAIL tx_second_load: err=%b out=%h valid=%b expected 0/%h/%b",
                     e, tx_out, out_flags[1], w2, exp_tx_valid);
        end
        // Ack toggle: cleared exactly three cycles later
        host_tx = ~host_tx;
        drive_host();
        @(negedge clk);
        apb_read(A_ST, d, e);
        tests++;
        if (d !== exp_status(0, 1'b0)) begin
            fails++;
            $display("FAIL tx_clear_3cyc: status got %h expected %h", d, exp_status(0, 1'b0));
        end
    endtask

    task automatic test_irq();
        int lat;
        logic [31:0] d;
        logic e;
        apb_write(A_IE, 32'h1, e);
        apb_read(A_IE, d, e);
`ifdef MAILBOX_IRQ_EN
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL irq_en_readback: got %h expected 1", d);
        end
        host_send($urandom, lat);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_push_cycle: irq=%b expected 0", irq);
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_after_push: irq=%b expected 1", irq);
        end
        apb_read(A_RX, d, e);
        void'(model_q.pop_front());
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_pop_cycle: irq=%b expected 1", irq);
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_after_pop: irq=%b expected 0", irq);
        end
`else
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL irq_en_absent: got %h expected 0", d);
        end
        host_send($urandom, lat);
        repeat (3) @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_tied_low: irq=%b expected 0", irq);
        end
        apb_read(A_RX, d, e);
        void'(model_q.pop_front());
`endif
        apb_write(A_IE, 32'h0, e);
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic e;
        apb_write(A_TX, $urandom, e);
        host_send($urandom, lat);
        host_send($urandom, lat);
        check_status("midflight_queued", 1'b1);
        usb_data = $urandom;
        @(negedge clk);
        host_rx = ~host_rx;
        drive_host();
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        tests++;
        if (out_flags !== 32'h0 || tx_out !== 32'h0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_midflight_outputs: flags=%h tx=%h irq=%b expected 0/0/0",
                     out_flags, tx_out, irq);
        end
        host_rx = 1'b0;
        host_tx = 1'b0;
        drive_host();
        exp_rx_ack = 1'b0;
        exp_tx_valid = 1'b0;
        model_q.delete();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check_status("reset_midflight_status", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rx_single();
        test_empty_read();
        test_full();
        test_rx_random();
        test_tx();
        test_irq();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
